// File: rtl/reduction_arbiter.sv
// Round-robin arbiter sharing one reduction tree among NUM_REQ lanes; a tag FIFO routes in-order results back.
// Optional REDUCTION_ARB_STATS_EN adds saturating grant_cnt/stall_cnt outputs.
`ifndef MAX_EMBEDDING_DIM
`define MAX_EMBEDDING_DIM 4
`endif
`ifndef INTEGER_WIDTH
`define INTEGER_WIDTH 8
`endif

// Handshakes: a transfer happens on a rising clk edge where vld && rdy; vld never waits on rdy upstream.
module reduction_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int INPUT_LEN  = `MAX_EMBEDDING_DIM,
  parameter int W_IN       = 2*`INTEGER_WIDTH,
  parameter int STEPS      = 1,
  parameter int W_OUT      = W_IN+STEPS,
  parameter int OUTPUT_LEN = INPUT_LEN>>STEPS,
  parameter int TAG_DEPTH  = 4,
  localparam int IDX_W     = $clog2(NUM_REQ),
  localparam int AW        = $clog2(TAG_DEPTH),
  localparam int PTR_W     = AW+1
)(
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [NUM_REQ-1:0]                          req_vld,
  output logic [NUM_REQ-1:0]                          req_rdy,
  input  logic [NUM_REQ-1:0][INPUT_LEN-1:0][W_IN-1:0] req_list,
  output logic                                        tree_vld,
  input  logic                                        tree_rdy,
  output logic [INPUT_LEN-1:0][W_IN-1:0]              tree_list,
  input  logic                                        res_vld,
  output logic                                        res_rdy,
  input  logic [OUTPUT_LEN-1:0][W_OUT-1:0]            res_list,
  output logic [NUM_REQ-1:0]                          resp_vld,
  input  logic [NUM_REQ-1:0]                          resp_rdy,
  output logic [OUTPUT_LEN-1:0][W_OUT-1:0]            resp_list,
  output logic                                        tag_err,
`ifdef REDUCTION_ARB_STATS_EN
  output logic [NUM_REQ-1:0][15:0]                    grant_cnt,
  output logic [15:0]                                 stall_cnt,
`endif
  output logic                                        state_dbg,
  output logic [IDX_W-1:0]                            rr_ptr_dbg,
  output logic [PTR_W-1:0]                            tag_count_dbg
);

  typedef enum logic {ARB, HOLD} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rr_ptr, lock_idx, lock_nxt, arb_idx, grant, rr_nxt;
  logic             arb_found, grant_vld, can_push, issue, pop, full, empty;
  logic [IDX_W-1:0] tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [IDX_W-1:0] head;

  // Cyclic priority search starting at rr_ptr.
  always_comb begin
    int j;
    arb_found = 1'b0;
    arb_idx   = '0;
    j         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!arb_found && req_vld[j]) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'(j);
      end
    end
  end

  assign grant     = (state == HOLD) ? lock_idx : arb_idx;
  assign grant_vld = (state == HOLD) ? req_vld[lock_idx] : arb_found;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head      = tag_mem[rd_ptr[AW-1:0]];

  // Outputs are gated by rst so every handshake signal drops the moment reset asserts.
  assign res_rdy   = rst && !empty && resp_rdy[head];
  assign pop       = res_vld && res_rdy;
  assign can_push  = !full || pop;
  assign tree_vld  = rst && grant_vld && can_push;
  assign issue     = tree_vld && tree_rdy;
  assign tree_list = req_list[grant];
  assign resp_list = res_list;
  assign rr_nxt    = (grant == IDX_W'(NUM_REQ-1)) ? '0 : grant + IDX_W'(1);

  always_comb begin
    req_rdy  = '0;
    resp_vld = '0;
    if (rst && grant_vld && tree_rdy && can_push) req_rdy[grant] = 1'b1;
    if (rst && res_vld && !empty) resp_vld[head] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    lock_nxt  = lock_idx;
    case (state)
      ARB: begin
        if (arb_found && !tree_rdy && can_push) begin
          state_nxt = HOLD;
          lock_nxt  = arb_idx;
        end
      end
      HOLD: begin
        if (issue) state_nxt = ARB;
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ARB;
      lock_idx <= '0;
      rr_ptr   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tag_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      lock_idx <= lock_nxt;
      if (issue) begin
        rr_ptr <= rr_nxt;
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (res_vld && empty) tag_err <= 1'b1;
    end
  end

  // Tag storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (issue) tag_mem[wr_ptr[AW-1:0]] <= grant;
  end

`ifdef REDUCTION_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (issue && grant == IDX_W'(i) && grant_cnt[i] != 16'hFFFF)
          grant_cnt[i] <= grant_cnt[i] + 16'd1;
      end
      if ((|req_vld) && !issue && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

  assign state_dbg     = (state == HOLD);
  assign rr_ptr_dbg    = rr_ptr;
  assign tag_count_dbg = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_reduction_arbiter.sv
// Directed bench for reduction_arbiter: round-robin issue, HOLD, tag FIFO full/pop, result routing, tag_err, reset.
module tb_reduction_arbiter;
  localparam int NR = 4;
  localparam int IL = 4;
  localparam int WI = 16;
  localparam int ST = 1;
  localparam int WO = WI + ST;
  localparam int OL = IL >> ST;
  localparam int TD = 4;

  typedef logic [IL-1:0][WI-1:0] vec_t;
  typedef logic [OL-1:0][WO-1:0] rvec_t;

  logic                clk;
  logic                rst;
  logic [NR-1:0]       req_vld;
  logic [NR-1:0]       req_rdy;
  logic [NR-1:0][IL-1:0][WI-1:0] req_list;
  logic                tree_vld;
  logic                tree_rdy;
  vec_t                tree_list;
  logic                res_vld;
  logic                res_rdy;
  rvec_t               res_list;
  logic [NR-1:0]       resp_vld;
  logic [NR-1:0]       resp_rdy;
  rvec_t               resp_list;
  logic                tag_err;
`ifdef REDUCTION_ARB_STATS_EN
  logic [NR-1:0][15:0] grant_cnt;
  logic [15:0]         stall_cnt;
`endif
  logic                state_dbg;
  logic [1:0]          rr_ptr_dbg;
  logic [2:0]          tag_count_dbg;

  int total;
  int bad;
  logic [1:0] exp_q[$];

  reduction_arbiter #(
    .NUM_REQ(NR), .INPUT_LEN(IL), .W_IN(WI), .STEPS(ST),
    .W_OUT(WO), .OUTPUT_LEN(OL), .TAG_DEPTH(TD)
  ) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_list(req_list),
    .tree_vld(tree_vld), .tree_rdy(tree_rdy), .tree_list(tree_list),
    .res_vld(res_vld), .res_rdy(res_rdy), .res_list(res_list),
    .resp_vld(resp_vld), .resp_rdy(resp_rdy), .resp_list(resp_list),
    .tag_err(tag_err),
`ifdef REDUCTION_ARB_STATS_EN
    .grant_cnt(grant_cnt), .stall_cnt(stall_cnt),
`endif
    .state_dbg(state_dbg), .rr_ptr_dbg(rr_ptr_dbg), .tag_count_dbg(tag_count_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t fill(input int v);
    vec_t f;
    for (int i = 0; i < IL; i++) f[i] = WI'(v);
    return f;
  endfunction

  // Bench-side tree: one reduction step sums adjacent pairs.
  function automatic rvec_t tsum(input vec_t v);
    rvec_t r;
    for (int j = 0; j < OL; j++) r[j] = WO'(v[2*j]) + WO'(v[2*j+1]);
    return r;
  endfunction

  function automatic logic [NR-1:0] oh(input int i);
    return NR'(1 << i);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    req_vld = '1;
    res_vld = 1'b1;
    #2;
    total++; if (tree_vld !== 1'b0) begin bad++; $display("FAIL reset_tree_vld got=%b want=0", tree_vld); end
    total++; if (req_rdy !== 4'b0000) begin bad++; $display("FAIL reset_req_rdy got=%b want=0000", req_rdy); end
    total++; if (res_rdy !== 1'b0 || resp_vld !== 4'b0000) begin bad++; $display("FAIL reset_resp got=%b/%b want=0/0000", res_rdy, resp_vld); end
    total++; if (tag_err !== 1'b0) begin bad++; $display("FAIL reset_tag_err got=%b want=0", tag_err); end
    total++; if (rr_ptr_dbg !== 2'd0 || tag_count_dbg !== 3'd0 || state_dbg !== 1'b0) begin bad++; $display("FAIL reset_state got=%0d/%0d/%0d want=0/0/0", rr_ptr_dbg, tag_count_dbg, state_dbg); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_vld = '0;
    res_vld = 1'b0;
  endtask

  task automatic test_rr_full;
    vec_t last;
    logic have;
    req_vld = '1; tree_rdy = 1'b1; resp_rdy = '1; res_vld = 1'b0;
    have = 1'b0; last = '0; exp_q.delete();
    for (int c = 0; c < 9; c++) begin
      if (c == 8) req_vld = '0;
      res_vld = have;
      if (have) res_list = tsum(last);
      @(negedge clk);
      if (c < 8) begin
        total++; if (req_rdy !== oh(c % 4)) begin bad++; $display("FAIL rr_grant c=%0d got=%b want=%b", c, req_rdy, oh(c % 4)); end
        total++; if (tree_list !== fill(c % 4 + 1)) begin bad++; $display("FAIL rr_list c=%0d got=%h want=%h", c, tree_list, fill(c % 4 + 1)); end
      end
      if (have) begin
        total++; if (resp_vld !== oh(int'(exp_q[0]))) begin bad++; $display("FAIL rr_resp c=%0d got=%b want=%b", c, resp_vld, oh(int'(exp_q[0]))); end
        total++; if (res_rdy !== 1'b1) begin bad++; $display("FAIL rr_res_rdy c=%0d got=%b want=1", c, res_rdy); end
      end
      tick();
      if (have) void'(exp_q.pop_front());
      if (c < 8) exp_q.push_back(2'(c % 4));
      have = (c < 8);
      last = fill(c % 4 + 1);
    end
    res_vld = 1'b0;
    total++; if (tag_count_dbg !== 3'd0) begin bad++; $display("FAIL rr_drain count got=%0d want=0", tag_count_dbg); end
  endtask

  task automatic test_hold;
    rvec_t e;
    req_list[2] = fill('h33);
    req_vld = 4'b0100; tree_rdy = 1'b0; resp_rdy = '1; res_vld = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) req_vld = 4'b0101;
      @(negedge clk);
      total++; if (tree_vld !== 1'b1 || req_rdy !== 4'b0000) begin bad++; $display("FAIL hold_vld_rdy c=%0d got=%b/%b want=1/0000", c, tree_vld, req_rdy); end
      total++; if (tree_list !== fill('h33)) begin bad++; $display("FAIL hold_list c=%0d got=%h want=%h", c, tree_list, fill('h33)); end
      if (c > 0) begin
        total++; if (state_dbg !== 1'b1) begin bad++; $display("FAIL hold_state c=%0d got=%b want=1", c, state_dbg); end
      end
      tick();
    end
    tree_rdy = 1'b1;
    @(negedge clk);
    total++; if (req_rdy !== 4'b0100) begin bad++; $display("FAIL hold_release got=%b want=0100", req_rdy); end
    tick();
    req_vld = '0; tree_rdy = 1'b0;
    total++; if (state_dbg !== 1'b0 || rr_ptr_dbg !== 2'd3 || tag_count_dbg !== 3'd1) begin bad++; $display("FAIL hold_after got=%0d/%0d/%0d want=0/3/1", state_dbg, rr_ptr_dbg, tag_count_dbg); end
    res_vld = 1'b1;
    res_list = tsum(fill('h33));
    e[0] = 17'h66; e[1] = 17'h66;
    @(negedge clk);
    total++; if (resp_vld !== 4'b0100 || resp_list !== e) begin bad++; $display("FAIL hold_resp got=%b/%h want=0100/%h", resp_vld, resp_list, e); end
    tick();
    res_vld = 1'b0;
    req_list[2] = fill(3);
  endtask

  task automatic test_full;
    req_vld = '1; tree_rdy = 1'b1; resp_rdy = '0; res_vld = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++; if (req_rdy !== oh((3 + c) % 4)) begin bad++; $display("FAIL full_fill c=%0d got=%b want=%b", c, req_rdy, oh((3 + c) % 4)); end
      tick();
    end
    total++; if (tag_count_dbg !== 3'd4) begin bad++; $display("FAIL full_count got=%0d want=4", tag_count_dbg); end
    res_vld = 1'b1;
    res_list = tsum(fill(4));
    @(negedge clk);
    total++; if (tree_vld !== 1'b0 || req_rdy !== 4'b0000) begin bad++; $display("FAIL full_block got=%b/%b want=0/0000", tree_vld, req_rdy); end
    total++; if (resp_vld !== 4'b1000 || res_rdy !== 1'b0) begin bad++; $display("FAIL full_wait got=%b/%b want=1000/0", resp_vld, res_rdy); end
    tick();
    resp_rdy = 4'b1000;
    @(negedge clk);
    total++; if (res_rdy !== 1'b1 || tree_vld !== 1'b1 || req_rdy !== 4'b1000) begin bad++; $display("FAIL full_pushpop got=%b/%b/%b want=1/1/1000", res_rdy, tree_vld, req_rdy); end
    tick();
    req_vld = '0;
    total++; if (tag_count_dbg !== 3'd4 || rr_ptr_dbg !== 2'd0) begin bad++; $display("FAIL full_after got=%0d/%0d want=4/0", tag_count_dbg, rr_ptr_dbg); end
    resp_rdy = '1;
    for (int c = 0; c < 4; c++) begin
      res_list = tsum(fill(c + 1));
      @(negedge clk);
      total++; if (resp_vld !== oh(c)) begin bad++; $display("FAIL full_drain c=%0d got=%b want=%b", c, resp_vld, oh(c)); end
      tick();
    end
    res_vld = 1'b0;
    total++; if (tag_count_dbg !== 3'd0) begin bad++; $display("FAIL full_empty got=%0d want=0", tag_count_dbg); end
  endtask

  task automatic test_order;
    vec_t v0, v1;
    rvec_t e0, e1;
    e0[0] = 17'd2; e0[1] = 17'd2;
    e1[0] = 17'd4; e1[1] = 17'd4;
    req_vld = 4'b0011; tree_rdy = 1'b1; resp_rdy = '1; res_vld = 1'b0;
    @(negedge clk);
    v0 = tree_list;
    tick();
    @(negedge clk);
    v1 = tree_list;
    tick();
    req_vld = '0;
    res_vld = 1'b1;
    res_list = tsum(v0);
    @(negedge clk);
    total++; if (resp_vld !== 4'b0001 || resp_list !== e0) begin bad++; $display("FAIL order_req0 got=%b/%h want=0001/%h", resp_vld, resp_list, e0); end
    tick();
    res_list = tsum(v1);
    @(negedge clk);
    total++; if (resp_vld !== 4'b0010 || resp_list !== e1) begin bad++; $display("FAIL order_req1 got=%b/%h want=0010/%h", resp_vld, resp_list, e1); end
    tick();
    res_vld = 1'b0;
  endtask

  task automatic test_tag_err;
    res_vld = 1'b1; resp_rdy = '1;
    @(negedge clk);
    total++; if (res_rdy !== 1'b0 || resp_vld !== 4'b0000 || tag_err !== 1'b0) begin bad++; $display("FAIL err_empty got=%b/%b/%b want=0/0000/0", res_rdy, resp_vld, tag_err); end
    tick();
    res_vld = 1'b0;
    for (int c = 0; c < 3; c++) begin
      total++; if (tag_err !== 1'b1) begin bad++; $display("FAIL err_sticky c=%0d got=%b want=1", c, tag_err); end
      tick();
    end
  endtask

  task automatic test_reset_mid;
    req_vld = '1; tree_rdy = 1'b1; resp_rdy = '0; res_vld = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    res_vld = 1'b1;
    #1;
    total++; if (tag_count_dbg !== 3'd3 || resp_vld !== 4'b0100) begin bad++; $display("FAIL mid_pre got=%0d/%b want=3/0100", tag_count_dbg, resp_vld); end
    #1;
    rst = 1'b0;
    #1;
    total++; if (tree_vld !== 1'b0 || req_rdy !== 4'b0000 || res_rdy !== 1'b0 || resp_vld !== 4'b0000) begin bad++; $display("FAIL mid_outs got=%b/%b/%b/%b want=0/0000/0/0000", tree_vld, req_rdy, res_rdy, resp_vld); end
    total++; if (tag_count_dbg !== 3'd0 || rr_ptr_dbg !== 2'd0 || tag_err !== 1'b0) begin bad++; $display("FAIL mid_state got=%0d/%0d/%b want=0/0/0", tag_count_dbg, rr_ptr_dbg, tag_err); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_vld = 4'b0010;
    res_vld = 1'b0;
    @(negedge clk);
    total++; if (tag_count_dbg !== 3'd0 || req_rdy !== 4'b0010) begin bad++; $display("FAIL mid_after got=%0d/%b want=0/0010", tag_count_dbg, req_rdy); end
    tick();
    req_vld = '0;
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b0;
    req_vld = '0; tree_rdy = 1'b0; res_vld = 1'b0; resp_rdy = '0; res_list = '0;
    for (int i = 0; i < NR; i++) req_list[i] = fill(i + 1);
    test_reset();
    test_rr_full();
    test_hold();
    test_full();
    test_order();
    test_tag_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case a task ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
